// File: rtl/mem_access_unit_pkg.sv
// Shared types for the memory access stage: bus size encoding, FSM states and
// the registered op record.
package mem_access_unit_pkg;

    localparam int MAU_XLEN = 64;

    typedef enum logic [2:0] {
        MSIZE_B = 3'd0,
        MSIZE_H = 3'd1,
        MSIZE_W = 3'd2,
        MSIZE_D = 3'd3
    } msize_t;

    typedef enum logic [2:0] {
        MAU_IDLE,
        MAU_REQ,
        MAU_WAIT,
        MAU_DONE,
        MAU_DRAIN
    } mau_state_t;

    // Widths are the widest supported; narrower configurations use the low bits.
    typedef struct packed {
        logic                is_load;
        logic                is_store;
        logic [1:0]          size;
        logic                is_unsigned;
        logic [MAU_XLEN-1:0] addr;
        logic [MAU_XLEN-1:0] wdata;
    } mem_access_t;

    function automatic msize_t to_msize(input logic [1:0] size);
        case (size)
            2'd0:    return MSIZE_B;
            2'd1:    return MSIZE_H;
            2'd2:    return MSIZE_W;
            default: return MSIZE_D;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Byte-lane alignment: write strobe and data shift for stores, extract and
// sign/zero-extend for loads. Purely combinational.
module lane_align #(
    parameter  int DATA_WIDTH = 64,
    localparam int BYTES      = DATA_WIDTH / 8,
    localparam int OFF_W      = $clog2(BYTES)
) (
    input  logic [1:0]            size,
    input  logic [OFF_W-1:0]      offset,
    input  logic                  is_unsigned,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic [BYTES-1:0]      strobe,
    output logic [DATA_WIDTH-1:0] wdata_shifted,
    output logic [DATA_WIDTH-1:0] rdata_ext
);

    logic [3:0]            nbytes;
    logic [DATA_WIDTH-1:0] rshift;
    logic [BYTES-1:0]      base_mask;
    logic                  sign_bit;
    logic                  fill_bit;

    assign nbytes = 4'd1 << size;
    assign rshift = rdata >> {offset, 3'b000};

    always_comb begin
        case (size)
            2'd0:    sign_bit = rshift[7];
            2'd1:    sign_bit = rshift[15];
            2'd2:    sign_bit = rshift[31];
            default: sign_bit = rshift[DATA_WIDTH-1];
        endcase
    end

    assign fill_bit = sign_bit & ~is_unsigned;

    genvar gi;
    generate
        for (gi = 0; gi < BYTES; gi++) begin : g_lane
            assign base_mask[gi]       = (4'(gi) < nbytes);
            assign rdata_ext[8*gi +: 8] = (4'(gi) < nbytes) ? rshift[8*gi +: 8] : {8{fill_bit}};
        end
    endgenerate

    assign strobe        = base_mask << offset;
    assign wdata_shifted = wdata << {offset, 3'b000};

endmodule

// File: rtl/mem_access_unit.sv
// Memory access stage: accepts one op from execute, issues at most one dbus
// transaction for it, and hands the aligned/extended result to writeback.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 64
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        in_is_load,
    input  logic                        in_is_store,
    input  logic [1:0]                  in_size,
    input  logic                        in_unsigned,
    input  logic [ADDR_WIDTH-1:0]       in_addr,
    input  logic [DATA_WIDTH-1:0]       in_wdata,
    input  logic                        flush,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_WIDTH-1:0]       out_data,
    output logic                        out_misalign,
    output logic                        dreq_valid,
    output logic [ADDR_WIDTH-1:0]       dreq_addr,
    output logic [2:0]                  dreq_size,
    output logic [DATA_WIDTH/8-1:0]     dreq_strobe,
    output logic [DATA_WIDTH-1:0]       dreq_data,
    input  logic                        dresp_addr_ok,
    input  logic                        dresp_data_ok,
    input  logic [DATA_WIDTH-1:0]       dresp_data
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFF_W = $clog2(BYTES);

    mau_state_t            state_reg;
    mem_access_t           op_reg;
    logic [DATA_WIDTH-1:0] out_data_reg;
    logic                  out_misalign_reg;

    mem_access_t           op_next;
    logic [OFF_W-1:0]      align_mask;
    logic                  misalign;
    logic [BYTES-1:0]      lane_strobe;
    logic [DATA_WIDTH-1:0] lane_wdata;
    logic [DATA_WIDTH-1:0] lane_rdata;

    always_comb begin
        op_next                        = '0;
        op_next.is_load                = in_is_load;
        op_next.is_store               = in_is_store;
        op_next.size                   = in_size;
        op_next.is_unsigned            = in_unsigned;
        op_next.addr[ADDR_WIDTH-1:0]   = in_addr;
        op_next.wdata[DATA_WIDTH-1:0]  = in_wdata;
        align_mask = OFF_W'((4'd1 << in_size) - 4'd1);
        // Doubleword ops cannot be carried by a 32-bit bus at all.
        misalign   = (in_is_load | in_is_store) &&
                     (((in_addr[OFF_W-1:0] & align_mask) != '0) ||
                      ((DATA_WIDTH == 32) && (in_size == 2'd3)));
    end

    lane_align #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_lane_align (
        .size         (op_reg.size),
        .offset       (op_reg.addr[OFF_W-1:0]),
        .is_unsigned  (op_reg.is_unsigned),
        .wdata        (op_reg.wdata[DATA_WIDTH-1:0]),
        .rdata        (dresp_data),
        .strobe       (lane_strobe),
        .wdata_shifted(lane_wdata),
        .rdata_ext    (lane_rdata)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg        <= MAU_IDLE;
            op_reg           <= '0;
            out_data_reg     <= '0;
            out_misalign_reg <= 1'b0;
        end else begin
            case (state_reg)
                MAU_IDLE: begin
                    if (in_valid && !flush) begin
                        op_reg <= op_next;
                        if (misalign) begin
                            out_data_reg     <= '0;
                            out_misalign_reg <= 1'b1;
                            state_reg        <= MAU_DONE;
                        end else if (!in_is_load && !in_is_store) begin
                            out_data_reg     <= in_wdata;
                            out_misalign_reg <= 1'b0;
                            state_reg        <= MAU_DONE;
                        end else begin
                            out_misalign_reg <= 1'b0;
                            state_reg        <= MAU_REQ;
                        end
                    end
                end
                MAU_REQ: begin
                    if (flush) begin
                        state_reg <= dresp_data_ok ? MAU_IDLE : MAU_DRAIN;
                    end else if (dresp_addr_ok && dresp_data_ok) begin
                        out_data_reg <= op_reg.is_load ? lane_rdata : '0;
                        state_reg    <= MAU_DONE;
                    end else if (dresp_addr_ok) begin
                        state_reg <= MAU_WAIT;
                    end
                end
                MAU_WAIT: begin
                    if (flush) begin
                        state_reg <= dresp_data_ok ? MAU_IDLE : MAU_DRAIN;
                    end else if (dresp_data_ok) begin
                        out_data_reg <= op_reg.is_load ? lane_rdata : '0;
                        state_reg    <= MAU_DONE;
                    end
                end
                MAU_DONE: begin
                    if (flush || out_ready) begin
                        state_reg <= MAU_IDLE;
                    end
                end
                MAU_DRAIN: begin
                    // The killed transaction must still complete on the bus.
                    if (dresp_data_ok) begin
                        state_reg <= MAU_IDLE;
                    end
                end
                default: state_reg <= MAU_IDLE;
            endcase
        end
    end

    assign in_ready     = (state_reg == MAU_IDLE);
    assign out_valid    = (state_reg == MAU_DONE);
    assign out_data     = out_data_reg;
    assign out_misalign = out_misalign_reg;

    assign dreq_valid  = (state_reg == MAU_REQ) || (state_reg == MAU_WAIT) ||
                         (state_reg == MAU_DRAIN);
    assign dreq_addr   = op_reg.addr[ADDR_WIDTH-1:0];
    assign dreq_size   = to_msize(op_reg.size);
    assign dreq_strobe = (dreq_valid && op_reg.is_store) ? lane_strobe : '0;
    assign dreq_data   = (dreq_valid && op_reg.is_store) ? lane_wdata : '0;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Parametrised successor to the single-cycle memory stage; issues dbus transactions for loads and stores of 1/2/4/8 bytes.
- Generates the byte strobe and shifted write data, and sign- or zero-extends load data.
- Stalls correctly on a multi-cycle bus and flags misaligned accesses instead of issuing them.
- Sits between execute and writeback with valid/ready handshakes on both sides.

Parameters:
- DATA_WIDTH, 64, bus/register data width; legal values 32 or 64.
- ADDR_WIDTH, 64, address width.
- BYTES, DATA_WIDTH/8, derived (localparam); bytes per bus beat.
- OFF_W, $clog2(BYTES), derived (localparam); address offset bits.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- in_valid  in  1  execute offers an op
- in_ready  out  1  unit can accept an op this cycle
- in_is_load  in  1  op is a load
- in_is_store  in  1  op is a store; load and store both low means pass-through
- in_size  in  2  log2 of access bytes: 0=B, 1=H, 2=W, 3=D
- in_unsigned  in  1  zero-extend the load result
- in_addr  in  ADDR_WIDTH  effective address
- in_wdata  in  DATA_WIDTH  store data (low bytes) or pass-through result
- flush  in  1  kill the current op
- out_valid  out  1  result ready for writeback
- out_ready  in  1  writeback accepts the result
- out_data  out  DATA_WIDTH  extended load data or pass-through value
- out_misalign  out  1  op was misaligned or illegal-size; no bus access was made
- dreq_valid  out  1  bus request
- dreq_addr  out  ADDR_WIDTH  request address
- dreq_size  out  3  msize_t encoding of the access size
- dreq_strobe  out  BYTES  byte write enables; all zero for loads
- dreq_data  out  DATA_WIDTH  write data shifted into lane position
- dresp_addr_ok  in  1  bus accepted the address
- dresp_data_ok  in  1  bus completed the transaction
- dresp_data  in  DATA_WIDTH  raw read beat

Behaviour:
- States: IDLE, REQ, WAIT, DONE, DRAIN. Async reset (resetn low) forces IDLE immediately.
- Outputs under reset: out_valid=0, out_misalign=0, out_data=0, dreq_valid=0, dreq_strobe=0.
- in_ready=1 only in IDLE. An op is accepted when in_valid & in_ready; all fields are registered on acceptance.
- Accepted op, neither load nor store: go to DONE with out_data=in_wdata (1-cycle latency).
- Misaligned op: in_addr[OFF_W-1:0] not a multiple of 2^in_size, or in_size=3 when DATA_WIDTH=32. Go to DONE with out_misalign=1 and out_data=0; no bus request is made.
- Aligned load/store: go to REQ.
  - dreq_valid=1 in REQ and WAIT.
  - addr, size, strobe and data are stable from the first valid cycle until data_ok.
  - strobe = ((1<<2^size)-1) << offset.
  - dreq_data = in_wdata << (8*offset).
  - Loads drive strobe=0 and data=0.
- REQ: addr_ok & data_ok in the same cycle goes to DONE; addr_ok alone goes to WAIT.
- WAIT: data_ok goes to DONE.
- On data_ok, a load captures dresp_data >> (8*offset), truncated to 2^size bytes, then sign-extended (in_unsigned=0) or zero-extended. A store sets out_data=0.
- Minimum latency from accept to out_valid for a bus op is 2 cycles, achieved when addr_ok and data_ok arrive together in the first REQ cycle.
- DONE: out_valid=1, and out_data/out_misalign are held until out_ready. Then go to IDLE; the next op can be accepted the following cycle.
- flush has priority over every other event in the same cycle:
  - IDLE: the offered op is not accepted.
  - DONE: drop the result and go to IDLE.
  - REQ/WAIT: go to DRAIN. dreq_valid and the request fields stay held until data_ok. The response is discarded, out_valid stays 0, then go to IDLE.
  - DRAIN: flush has no further effect.
- DRAIN with data_ok in the same cycle as the flush: go directly to IDLE.
- No outputs change during a back-pressured DONE.

Decomposition:
- The shared pipes package gains an mau_state_t enum, a mem_access_t struct (is_load, is_store, size, unsigned, addr, wdata) and a function mapping size to msize_t.
- Sub-module lane_align (combinational) computes strobe, write-data shift and load extract/extend. It is reused later by the cache.

Test Plan:
- Store 8 bytes at 0x1000, data 0x1122334455667788, addr_ok & data_ok same cycle -> one request with strobe 0xFF and data unchanged; out_valid 2 cycles after accept.
- Load H signed at 0x2006, dresp_data 0x8001_0000_0000_0000 with data_ok 3 cycles late -> request held stable throughout; out_data 0xFFFF_FFFF_FFFF_8001.
- Store B at 0x3003, data 0xAB -> strobe 0x08, dreq_data byte3=0xAB; load BU at the same address returning 0xAB<<24 -> out_data 0xAB.
- Load W at 0x4002 -> out_misalign=1, dreq_valid never asserted, out_data=0.
- Flush in WAIT -> dreq_valid held until data_ok, out_valid stays 0, in_ready returns 1 the cycle after data_ok.
- out_ready low for 4 cycles in DONE -> out_data stable and in_ready=0. resetn low mid-REQ -> dreq_valid=0 in the same cycle, state IDLE.
